// File: rtl/ram_block_copier_pkg.sv
// -----------------------------------------------------------------------------
// ram_block_copier_pkg
//   Shared definitions for the RAM block copier and its bench:
//   FSM state encodings, copy-direction constants, default widths and
//   the overlap test that chooses the copy direction.
// -----------------------------------------------------------------------------
package ram_block_copier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } copier_state_e;

  typedef enum logic {
    DIR_FWD  = 1'b0,
    DIR_BACK = 1'b1
  } copy_dir_e;

  localparam int unsigned DEF_ADDR_W = 14;
  localparam int unsigned DEF_DATA_W = 16;

  // The destination starts inside the source block (0 < dst-src < len):
  // a forward copy would overwrite source words before reading them, so
  // walk the block from its top end instead. Arguments are zero-extended.
  function automatic copy_dir_e pick_dir(input logic [31:0] diff,
                                         input logic [31:0] len);
    if ((diff != 32'd0) && (diff < len)) begin
      return DIR_BACK;
    end else begin
      return DIR_FWD;
    end
  endfunction

endpackage

// File: rtl/ram_block_copier_copy_ptr.sv
// -----------------------------------------------------------------------------
// copy_ptr
//   ADDR_W-bit address pointer that can be loaded, or stepped by +1/-1.
//   Arithmetic is modulo 2**ADDR_W, so it wraps naturally at both ends.
// Ports:
//   clock     in   clock
//   reset_n   in   synchronous active-low reset (pointer -> 0)
//   i_load    in   load i_value (has priority over i_step)
//   i_value   in   value to load
//   i_step    in   step the pointer one word
//   i_dir     in   DIR_FWD: +1, DIR_BACK: -1
//   o_ptr     out  current pointer (registered)
// -----------------------------------------------------------------------------
module copy_ptr
  import ram_block_copier_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_value,
  input  logic              i_step,
  input  copy_dir_e         i_dir,
  output logic [ADDR_W-1:0] o_ptr
);

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_next;

  // Next pointer value: load, step with wrap, or hold.
  always_comb begin
    w_ptr_next = r_ptr;
    if (i_load) begin
      w_ptr_next = i_value;
    end else if (i_step) begin
      if (i_dir == DIR_BACK) begin
        w_ptr_next = r_ptr - PTR_ONE;
      end else begin
        w_ptr_next = r_ptr + PTR_ONE;
      end
    end else begin
      w_ptr_next = r_ptr;
    end
  end

  // Pointer register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ptr <= {ADDR_W{1'b0}};
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ram_block_copier.sv
// -----------------------------------------------------------------------------
// ram_block_copier
//   Memory-port initiator that copies len words from src to dst with
//   memmove semantics (overlapping blocks copy correctly). Each word takes a
//   READ cycle (latch mem_out) followed by a WRITE cycle (store it).
// Ports:
//   clock        in   clock, all state on posedge
//   reset_n      in   synchronous active-low reset; aborts a copy at once
//   start        in   copy request, sampled only in IDLE
//   src, dst     in   block base addresses, sampled with start
//   len          in   word count 0..2**ADDR_W, sampled with start
//   busy         out  high while reading/writing
//   done         out  one-cycle completion pulse
//   mem_address  out  RAM address
//   mem_in       out  RAM write data
//   mem_load     out  RAM write enable
//   mem_out      in   combinational RAM read data at mem_address
// -----------------------------------------------------------------------------
module ram_block_copier
  import ram_block_copier_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};

  copier_state_e     r_state;
  copier_state_e     w_state_next;
  copy_dir_e         r_dir;
  copy_dir_e         w_dir_start;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_hold;

  logic              w_accept;
  logic              w_step;
  logic [ADDR_W-1:0] w_diff;
  logic [ADDR_W-1:0] w_rp_init;
  logic [ADDR_W-1:0] w_wp_init;
  logic [ADDR_W-1:0] w_rp;
  logic [ADDR_W-1:0] w_wp;

  // A non-empty copy begins only from IDLE; an empty one goes straight to DONE.
  assign w_accept = (r_state == ST_IDLE) && start && (len != CNT_ZERO);
  assign w_step   = (r_state == ST_WRITE);

  // Direction choice and start pointers. Backward copies begin at the last
  // word of each block; len=2**ADDR_W truncates to 0 in the low bits, which
  // still gives base-1 modulo 2**ADDR_W (only reachable as BACK if dst!=src).
  always_comb begin
    w_diff      = dst - src;
    w_dir_start = pick_dir(32'(w_diff), 32'(len));
    if (w_dir_start == DIR_BACK) begin
      w_rp_init = src + len[ADDR_W-1:0] - ADDR_ONE;
      w_wp_init = dst + len[ADDR_W-1:0] - ADDR_ONE;
    end else begin
      w_rp_init = src;
      w_wp_init = dst;
    end
  end

  copy_ptr #(.ADDR_W(ADDR_W)) u_rp (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_accept),
    .i_value (w_rp_init),
    .i_step  (w_step),
    .i_dir   (r_dir),
    .o_ptr   (w_rp)
  );

  copy_ptr #(.ADDR_W(ADDR_W)) u_wp (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_accept),
    .i_value (w_wp_init),
    .i_step  (w_step),
    .i_dir   (r_dir),
    .o_ptr   (w_wp)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (len == CNT_ZERO) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_READ;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_READ: begin
        w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (r_cnt == CNT_ONE) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_READ;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Word counter, direction and read-data hold register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt  <= CNT_ZERO;
      r_dir  <= DIR_FWD;
      r_hold <= {DATA_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_cnt <= len;
        r_dir <= w_dir_start;
      end else if (r_state == ST_WRITE) begin
        r_cnt <= r_cnt - CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end
      if (r_state == ST_READ) begin
        r_hold <= mem_out;
      end else begin
        r_hold <= r_hold;
      end
    end
  end

  // FSM output decode from registered state, pointers and hold register.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_address = {ADDR_W{1'b0}};
    mem_in      = {DATA_W{1'b0}};
    mem_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_READ: begin
        busy        = 1'b1;
        mem_address = w_rp;
      end
      ST_WRITE: begin
        busy        = 1'b1;
        mem_address = w_wp;
        mem_in      = r_hold;
        mem_load    = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_block_copier.sv
// -----------------------------------------------------------------------------
// tb_ram_block_copier
//   Pairs the copier with a RAM16K-style memory (combinational read,
//   write on posedge when load) preloaded with mem[i] = 16'h1000 + i,
//   runs a table of directed copies and then a reset-abort sequence.
//   The copy for a start sampled at edge E is timed in edges after E:
//   n = 0 is the cycle right after E, so "done in cycle E+2*len+1"
//   means done is first seen at n = 2*len.
// -----------------------------------------------------------------------------
module tb_ram_block_copier;
  import ram_block_copier_pkg::*;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 16;
  localparam int RAM_WORDS = 1 << ADDR_W;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;

  logic [DATA_W-1:0] mem [RAM_WORDS];
  logic              preload;

  int checks = 0;
  int passes = 0;

  ram_block_copier #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_out     (mem_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM16K model, with a one-edge bulk preload used between tests.
  assign mem_out = mem[mem_address];
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < RAM_WORDS; i++) mem[i] <= 16'h1000 + 16'(i);
    end else if (mem_load) begin
      mem[mem_address] <= mem_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_preload();
    @(negedge clock);
    preload = 1'b1;
    @(posedge clock);
    #1;
    preload = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] orig(input logic [ADDR_W-1:0] a);
    return 16'h1000 + {2'b00, a};
  endfunction

  // Issue one copy and observe it until a few cycles past done.
  task automatic run_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input logic [ADDR_W:0] l, input logic hold,
                          output int done_at, output int busy_n, output int first_wa,
                          output int done_cnt, output int load_n, output int load_done);
    done_at = -1; busy_n = 0; first_wa = -1; done_cnt = 0; load_n = 0; load_done = 0;
    @(negedge clock);
    src = s; dst = d; len = l; start = 1'b1;
    @(posedge clock);
    #1;
    if (hold) begin
      // Keep requesting with different operands; none may be picked up.
      src = s + 14'd7; dst = d + 14'd3; len = l + 15'd1;
    end else begin
      start = 1'b0;
    end
    for (int n = 0; n < 2 * int'(l) + 12; n++) begin
      if (busy) busy_n++;
      if (mem_load) begin
        load_n++;
        if (first_wa < 0) first_wa = int'(mem_address);
      end
      if (done) begin
        if (done_at < 0) done_at = n;
        done_cnt++;
        if (mem_load) load_done++;
        start = 1'b0;
      end
      @(posedge clock);
      #1;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] s;
    logic [ADDR_W-1:0] d;
    logic [ADDR_W:0]   l;
    logic              hold;
    int                exp_first_wa;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int done_at, busy_n, first_wa, done_cnt, load_n, load_done;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] sa;

    // Hand-computed first write addresses (BACK starts at dst+len-1).
    vecs[0] = '{s: 14'd100,   d: 14'd200, l: 15'd4, hold: 1'b0, exp_first_wa: 200};
    vecs[1] = '{s: 14'd10,    d: 14'd12,  l: 15'd4, hold: 1'b0, exp_first_wa: 15};
    vecs[2] = '{s: 14'd12,    d: 14'd10,  l: 15'd4, hold: 1'b0, exp_first_wa: 10};
    vecs[3] = '{s: 14'd16380, d: 14'd100, l: 15'd6, hold: 1'b0, exp_first_wa: 100};
    vecs[4] = '{s: 14'd5,     d: 14'd7,   l: 15'd0, hold: 1'b0, exp_first_wa: -1};
    vecs[5] = '{s: 14'd50,    d: 14'd60,  l: 15'd3, hold: 1'b1, exp_first_wa: 60};

    reset_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0; preload = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load", 32'(mem_load), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_din", 32'(mem_in), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_preload();
      run_copy(vecs[i].s, vecs[i].d, vecs[i].l, vecs[i].hold,
               done_at, busy_n, first_wa, done_cnt, load_n, load_done);
      chk($sformatf("v%0d_done_lat", i), 32'(done_at), 32'(2 * int'(vecs[i].l)));
      chk($sformatf("v%0d_busy_cyc", i), 32'(busy_n), 32'(2 * int'(vecs[i].l)));
      chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt), 32'd1);
      chk($sformatf("v%0d_done_load", i), 32'(load_done), 32'd0);
      chk($sformatf("v%0d_writes", i), 32'(load_n), 32'(vecs[i].l));
      chk($sformatf("v%0d_first_wa", i), 32'(first_wa), 32'(vecs[i].exp_first_wa));
      // Destination holds the original source words (memmove result).
      for (int k = 0; k < int'(vecs[i].l); k++) begin
        a  = vecs[i].d + 14'(k);
        sa = vecs[i].s + 14'(k);
        chk($sformatf("v%0d_word%0d", i, k), 32'(mem[a]), 32'(orig(sa)));
      end
      // Words just outside the destination block are untouched.
      a = vecs[i].d - 14'd1;
      chk($sformatf("v%0d_below", i), 32'(mem[a]), 32'(orig(a)));
      a = vecs[i].d + vecs[i].l[ADDR_W-1:0];
      chk($sformatf("v%0d_above", i), 32'(mem[a]), 32'(orig(a)));
    end

    // Reset during the WRITE of word 2 of an 8-word copy 300 -> 400.
    do_preload();
    @(negedge clock);
    src = 14'd300; dst = 14'd400; len = 15'd8; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("abort_in_write", 32'(mem_load), 32'd1);
    chk("abort_wr_addr", 32'(mem_address), 32'd402);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_load", 32'(mem_load), 32'd0);
    chk("abort_addr", 32'(mem_address), 32'd0);
    done_cnt = 0;
    load_n = 0;
    for (int n = 0; n < 20; n++) begin
      if (n == 2) reset_n = 1'b1;
      if (done) done_cnt++;
      if (mem_load) load_n++;
      @(posedge clock);
      #1;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_no_writes", 32'(load_n), 32'd0);
    chk("abort_w0", 32'(mem[400]), 32'(orig(14'd300)));
    chk("abort_w1", 32'(mem[401]), 32'(orig(14'd301)));
    chk("abort_w2", 32'((mem[402] == orig(14'd302)) || (mem[402] == orig(14'd402))), 32'd1);
    for (int k = 403; k < 408; k++) begin
      a = 14'(k);
      chk($sformatf("abort_untouched%0d", k), 32'(mem[a]), 32'(orig(a)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
